// File: rtl/spi_mem_bridge_if.sv
// SPI pin bundle between an SPI master and the spi_mem_bridge slave.
interface spi_mem_bridge_if;
    logic MOSI;
    logic SS_n;
    logic MISO;

    modport master (
        output MOSI,
        output SS_n,
        input  MISO
    );

    modport slave (
        input  MOSI,
        input  SS_n,
        output MISO
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// SPI slave with a single-port RAM behind a 2-bit command frame protocol.
// Define SPI_MEM_AUTOINC_EN for post-access address auto-increment.
module spi_mem_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_mem_bridge_if.slave  spi
);

    localparam int W  = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W+1:0]    rx_sr;
    logic [CW-1:0]   bit_cnt;
    logic            done;
    logic            full;
    logic            full_rd;
    logic            rx_valid;
    logic            rx_rd;
    logic            take;
    logic            last;

    logic [1:0]      rx_cmd;
    logic [W-1:0]    rx_pay;
    logic [AW-1:0]   rx_addr;

    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic            rd_pend;
    logic            wr_ok;
    logic            rd_ok;
    logic            we;
    logic            re;

    logic [W-1:0]    mem [MEM_DEPTH];
    logic [W-1:0]    dout;
    logic            tx_valid;
    logic [W-1:0]    tx_sr;
    logic [CW-1:0]   tx_cnt;
    logic            miso;

`ifdef SPI_MEM_AUTOINC_EN
    localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction
`endif

    assign take = !spi.SS_n && !done &&
                  (state inside {WRITE, READ_ADD, READ_DATA});
    assign last = take && (bit_cnt == CW'(W));

    assign rx_cmd  = rx_sr[W+1:W];
    assign rx_pay  = rx_sr[W-1:0];
    assign rx_addr = rx_pay[AW-1:0];

    assign wr_ok = 32'(wr_addr) < MEM_DEPTH;
    assign rd_ok = 32'(rd_addr) < MEM_DEPTH;
    assign we    = rx_valid && (rx_cmd == 2'b01) && wr_ok;
    assign re    = rx_valid && (rx_cmd == 2'b11) && rx_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (spi.SS_n) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = CHK_CMD;
                CHK_CMD: begin
                    if (!spi.MOSI) begin
                        state_nx = WRITE;
                    end else if (rd_pend) begin
                        state_nx = READ_DATA;
                    end else begin
                        state_nx = READ_ADD;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    // done blocks further shifting until SS_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr    <= '0;
            bit_cnt  <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            full_rd  <= 1'b0;
            rx_valid <= 1'b0;
            rx_rd    <= 1'b0;
        end else begin
            full     <= last;
            full_rd  <= last && (state == READ_DATA);
            rx_valid <= full;
            rx_rd    <= full_rd;
            if (spi.SS_n) begin
                bit_cnt <= '0;
                done    <= 1'b0;
            end else if (state == CHK_CMD) begin
                rx_sr   <= {rx_sr[W:0], spi.MOSI};
                bit_cnt <= '0;
            end else if (take) begin
                rx_sr <= {rx_sr[W:0], spi.MOSI};
                if (last) begin
                    done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= re;
            if (rx_valid) begin
                unique case (rx_cmd)
                    2'b00: wr_addr <= rx_addr;
                    2'b01: begin
`ifdef SPI_MEM_AUTOINC_EN
                        wr_addr <= nxt(wr_addr);
`endif
                    end
                    2'b10: begin
                        rd_addr <= rx_addr;
                        rd_pend <= 1'b1;
                    end
                    2'b11: begin
                        if (rx_rd) begin
`ifdef SPI_MEM_AUTOINC_EN
                            rd_addr <= nxt(rd_addr);
`else
                            rd_pend <= 1'b0;
`endif
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= rx_pay;
        end
        if (re) begin
            dout <= rd_ok ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso   <= 1'b0;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else if (spi.SS_n) begin
            miso   <= 1'b0;
            tx_cnt <= '0;
        end else if (tx_valid) begin
            miso   <= dout[W-1];
            tx_sr  <= {dout[W-2:0], 1'b0};
            tx_cnt <= CW'(W - 1);
        end else if (tx_cnt != '0) begin
            miso   <= tx_sr[W-1];
            tx_sr  <= {tx_sr[W-2:0], 1'b0};
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            miso <= 1'b0;
        end
    end

    assign spi.MISO = miso;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: 8-bit/256-word and 16-bit/1000-word
// instances, reference model with a queue of expected read words.
module tb_spi_mem_bridge;

`ifdef SPI_MEM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    spi_mem_bridge_if if0 ();
    spi_mem_bridge_if if1 ();

    spi_mem_bridge #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .MEM_DEPTH  (256)
    ) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (if0)
    );

    spi_mem_bridge #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10),
        .MEM_DEPTH  (1000)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          wid [2] = '{8, 16};
    int          awd [2] = '{8, 10};
    int          dep [2] = '{256, 1000};
    logic [15:0] mm  [2][1024];
    int          mw  [2];
    int          mr  [2];
    bit          mp  [2];
    logic [15:0] sb  [$];

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ss(input int sel, input logic v);
        if (sel == 0) if0.SS_n = v;
        else          if1.SS_n = v;
    endtask

    task automatic set_mosi(input int sel, input logic v);
        if (sel == 0) if0.MOSI = v;
        else          if1.MOSI = v;
    endtask

    function automatic logic miso(input int sel);
        return (sel == 0) ? if0.MISO : if1.MISO;
    endfunction

    function automatic int wrap(input int sel, input int a);
        if (a == dep[sel] - 1) return 0;
        return (a + 1) % (1 << awd[sel]);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mw[s] = 0;
            mr[s] = 0;
            mp[s] = 1'b0;
        end
    endtask

    task automatic model(input int sel, input logic [1:0] cmd,
                         input logic [15:0] pay, output bit ro,
                         output logic [15:0] exp);
        int  a;
        bit  in_rd;
        ro    = 1'b0;
        exp   = '0;
        a     = int'(pay) % (1 << awd[sel]);
        in_rd = cmd[1] && mp[sel];
        case (cmd)
            2'b00: mw[sel] = a;
            2'b01: begin
                if (mw[sel] < dep[sel]) mm[sel][mw[sel]] = pay;
                if (AUTOINC) mw[sel] = wrap(sel, mw[sel]);
            end
            2'b10: begin
                mr[sel] = a;
                mp[sel] = 1'b1;
            end
            default: begin
                if (in_rd) begin
                    ro  = 1'b1;
                    exp = (mr[sel] < dep[sel]) ? mm[sel][mr[sel]] : 16'h0;
                    if (AUTOINC) mr[sel] = wrap(sel, mr[sel]);
                    else         mp[sel] = 1'b0;
                end
            end
        endcase
    endtask

    task automatic frame(input int sel, input logic [1:0] cmd,
                         input logic [15:0] pay, input int cut = -1,
                         input bit extra = 1'b0, input bit rst_mid = 1'b0);
        int          w;
        int          n;
        logic [17:0] bits;
        logic [9:0]  xb;
        bit          ro;
        logic [15:0] exp;
        logic [15:0] got;
        logic [15:0] ex;
        w  = wid[sel];
        n  = w + 2;
        xb = {2'b00, 8'h30};
        if (w == 8) bits = {8'h00, cmd, pay[7:0]};
        else        bits = {cmd, pay};
        @(negedge clk);
        set_ss(sel, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == cut) begin
                set_ss(sel, 1'b1);
                set_mosi(sel, 1'b0);
                repeat (2) @(negedge clk);
                return;
            end
            set_mosi(sel, bits[n-1-i]);
        end
        model(sel, cmd, pay, ro, exp);
        if (ro) sb.push_back(exp);
        repeat (3) @(negedge clk);
        got = '0;
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            got[w-1-k] = miso(sel);
            if (rst_mid && k == 0) begin
                check("pre_rst_msb", 16'(got[w-1]), 16'(exp[w-1]));
                rst_n = 1'b0;
                #1;
                check("rst_mid_miso", 16'(miso(sel)), 16'h0);
                set_ss(sel, 1'b1);
                set_mosi(sel, 1'b0);
                if (ro) void'(sb.pop_front());
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        if (cmd == 2'b11) begin
            if (ro) begin
                ex = sb.pop_front();
                if (!$isunknown(ex)) check("rd_word", got, ex);
                check("miso_after", 16'(miso(sel)), 16'h0);
            end else begin
                check("no_readout", got, 16'h0);
            end
        end
        if (extra) begin
            for (int j = 0; j < 10; j++) begin
                set_mosi(sel, xb[9-j]);
                @(negedge clk);
            end
        end
        set_ss(sel, 1'b1);
        set_mosi(sel, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 1024; i++) mm[s][i] = 'x;
        model_reset();
        rst_n    = 1'b0;
        if0.MOSI = 1'b0;
        if0.SS_n = 1'b1;
        if1.MOSI = 1'b0;
        if1.SS_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if0.MOSI = 1'($urandom);
            if0.SS_n = 1'($urandom);
            if1.MOSI = 1'($urandom);
            if1.SS_n = 1'($urandom);
            #1;
            check("rst_miso0", 16'(if0.MISO), 16'h0);
            check("rst_miso1", 16'(if1.MISO), 16'h0);
        end
        @(negedge clk);
        if0.MOSI = 1'b0;
        if0.SS_n = 1'b1;
        if1.MOSI = 1'b0;
        if1.SS_n = 1'b1;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);

        frame(0, 2'b00, 16'h05);
        frame(0, 2'b01, 16'hA5);
        frame(0, 2'b10, 16'h05);
        frame(0, 2'b11, 16'h00);

        frame(0, 2'b01, 16'h3C, 5);
        frame(0, 2'b10, 16'h05);
        frame(0, 2'b11, 16'hFF);

        frame(0, 2'b00, 16'h10);
        frame(0, 2'b01, 16'h5A);
        frame(0, 2'b00, 16'h11);
        frame(0, 2'b01, 16'hC3);
        frame(0, 2'b10, 16'h10);
        frame(0, 2'b11, 16'h00);
        frame(0, 2'b10, 16'h11);
        frame(0, 2'b11, 16'h00);
        frame(0, 2'b11, 16'h00);

        frame(0, 2'b00, 16'hFF);
        frame(0, 2'b01, 16'h11);
        frame(0, 2'b01, 16'h22);
        frame(0, 2'b10, 16'hFF);
        frame(0, 2'b11, 16'h00);
        frame(0, 2'b11, 16'h00);

        frame(0, 2'b10, 16'h05);
        frame(0, 2'b10, 16'h10);
        frame(0, 2'b11, 16'h00);

        frame(0, 2'b00, 16'h20, -1, 1'b1);
        frame(0, 2'b01, 16'h77);
        frame(0, 2'b10, 16'h20);
        frame(0, 2'b11, 16'h00);

        frame(1, 2'b00, 16'h03E7);
        frame(1, 2'b01, 16'hBEEF);
        frame(1, 2'b10, 16'h03E7);
        frame(1, 2'b11, 16'h0000);
        frame(1, 2'b00, 16'h03E8);
        frame(1, 2'b01, 16'hFFFF);
        frame(1, 2'b10, 16'h03E8);
        frame(1, 2'b11, 16'h0000);
        frame(1, 2'b10, 16'h03E7);
        frame(1, 2'b11, 16'h0000);
        frame(1, 2'b00, 16'hFC05);
        frame(1, 2'b01, 16'h1234);
        frame(1, 2'b10, 16'h0005);
        frame(1, 2'b11, 16'h0000);

        frame(0, 2'b10, 16'h05);
        frame(0, 2'b11, 16'h00, -1, 1'b0, 1'b1);
        frame(0, 2'b11, 16'h00);
        frame(0, 2'b10, 16'h05);
        frame(0, 2'b11, 16'h00);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
